// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds single bytes from N_REQ
// requesters into one UART transmitter. It handles the start/busy handshake
// with a start timeout and inserts a fixed idle gap between frames.
module uart_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int TMO_CYCLES = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               ENABLE,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [8*N_REQ-1:0] REQ_DATA,
    output logic [N_REQ-1:0]   REQ_ACK,
    output logic               TX_START,
    output logic [7:0]         TX_DATA,
    input  logic               TX_BUSY,
    output logic [2:0]         GRANT_ID,
    output logic               ACTIVE,
    output logic               ERR_TMO
);

    // Pointer and counter sizing. The counter must reach the larger of the
    // timeout and gap lengths.
    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW1     = PTR_W + 1;
    localparam int CNT_MAX = (TMO_CYCLES > GAP_CYCLES) ? TMO_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX >= 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TMO_CYCLES > 0) ? TMO_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // When no gap is configured, a finished or failed frame goes straight
    // back to IDLE.
    localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic [N_REQ-1:0]   req_ack_q, req_ack_d;
    logic               err_tmo_q, err_tmo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_meta_q, busy_meta_d;
    logic               busy_s_q, busy_s_d;

    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [PW1-1:0]     cand;
    logic [7:0]         win_data;
    logic [N_REQ-1:0]   win_onehot;
    logic [PTR_W-1:0]   ptr_next;

    // Two-stage synchronizer input for the transmitter busy flag.
    always_comb begin
        busy_meta_d = TX_BUSY;
        busy_s_d    = busy_meta_q;
    end

    // Round-robin scan: first set request at or above the pointer, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = PW1'(ptr_q) + PW1'(i);
            if (cand >= PW1'(N_REQ)) begin
                cand = cand - PW1'(N_REQ);
            end
            if (!found && REQ[cand[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[PTR_W-1:0];
            end
        end
    end

    // Winner's byte, its one-hot acknowledge and the pointer that follows it.
    always_comb begin
        win_data   = '0;
        win_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == PTR_W'(i)) begin
                win_data      = REQ_DATA[8*i +: 8];
                win_onehot[i] = 1'b1;
            end
        end
        ptr_next = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);
    end

    // Frame FSM: grant in IDLE, wait for busy in START (with timeout),
    // wait for busy to drop in SEND, then hold off for the gap.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        tx_data_d  = tx_data_q;
        tx_start_d = tx_start_q;
        req_ack_d  = '0;
        err_tmo_d  = 1'b0;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (ENABLE && found) begin
                    state_d    = START;
                    tx_data_d  = win_data;
                    grant_id_d = 3'(winner);
                    req_ack_d  = win_onehot;
                    tx_start_d = 1'b1;
                    ptr_d      = ptr_next;
                    cnt_d      = '0;
                end
            end
            START: begin
                if (busy_s_q) begin
                    tx_start_d = 1'b0;
                    state_d    = SEND;
                    cnt_d      = '0;
                end else if (cnt_q == TMO_LAST) begin
                    tx_start_d = 1'b0;
                    err_tmo_d  = 1'b1;
                    state_d    = AFTER_FRAME;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SEND: begin
                if (!busy_s_q) begin
                    state_d = AFTER_FRAME;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_id_q  <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            req_ack_q   <= '0;
            err_tmo_q   <= 1'b0;
            cnt_q       <= '0;
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            req_ack_q   <= req_ack_d;
            err_tmo_q   <= err_tmo_d;
            cnt_q       <= cnt_d;
            busy_meta_q <= busy_meta_d;
            busy_s_q    <= busy_s_d;
        end
    end

    assign REQ_ACK  = req_ack_q;
    assign TX_START = tx_start_q;
    assign TX_DATA  = tx_data_q;
    assign GRANT_ID = grant_id_q;
    assign ERR_TMO  = err_tmo_q;
    assign ACTIVE   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter. A small
// transmitter model answers TX_START with TX_BUSY; each frame is checked
// against expectations derived from round-robin order and handshake timing.
module tb_uart_tx_arbiter;

    localparam int N_REQ = 4;
    localparam int TMO   = 64;
    localparam int GAP   = 2;

    logic                CLK;
    logic                RESETN;
    logic                ENABLE;
    logic [N_REQ-1:0]    REQ;
    logic [8*N_REQ-1:0]  REQ_DATA;
    logic [N_REQ-1:0]    REQ_ACK;
    logic                TX_START;
    logic [7:0]          TX_DATA;
    logic                TX_BUSY;
    logic [2:0]          GRANT_ID;
    logic                ACTIVE;
    logic                ERR_TMO;

    int checks   = 0;
    int failures = 0;

    // Transmitter model state: busy rises on the busy_dly-th cycle TX_START
    // is seen high (0 = never answers) and stays high for busy_len cycles.
    int busy_dly  = 0;
    int busy_len  = 0;
    int start_cnt = 0;
    int busy_rem  = 0;

    // Reference pointer: where the next round-robin scan begins.
    int ptr_model = 0;

    uart_tx_arbiter #(
        .N_REQ      (N_REQ),
        .TMO_CYCLES (TMO),
        .GAP_CYCLES (GAP)
    ) dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .ENABLE   (ENABLE),
        .REQ      (REQ),
        .REQ_DATA (REQ_DATA),
        .REQ_ACK  (REQ_ACK),
        .TX_START (TX_START),
        .TX_DATA  (TX_DATA),
        .TX_BUSY  (TX_BUSY),
        .GRANT_ID (GRANT_ID),
        .ACTIVE   (ACTIVE),
        .ERR_TMO  (ERR_TMO)
    );

    // Free-running 100 MHz clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Counts one comparison and reports it when it does not hold.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advances to the next falling edge and steps the transmitter model.
    task automatic tick();
        @(negedge CLK);
        if (TX_BUSY) begin
            busy_rem--;
            if (busy_rem <= 0) TX_BUSY = 1'b0;
        end else if (TX_START === 1'b1) begin
            start_cnt++;
            if (busy_dly != 0 && start_cnt == busy_dly) begin
                TX_BUSY  = 1'b1;
                busy_rem = busy_len;
            end
        end else begin
            start_cnt = 0;
        end
    endtask

    // First set request at or above ptr, wrapping around.
    function automatic int pickWinner(input logic [N_REQ-1:0] mask, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (mask[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    // Runs one frame from IDLE. mode: 0 plain, 1 noisy REQ/REQ_DATA after
    // the grant, 2 drop ENABLE mid-SEND with REQ[0] raised, 3 reset mid-SEND.
    task automatic applyStimulus(input logic [N_REQ-1:0] mask, input logic [8*N_REQ-1:0] data,
                                 input int dly, input int len, input int mode);
        int         winner;
        int         hi, tail, errs, acks, unstable, guard;
        bit         tmo, low_seen;
        logic [7:0] exp_data;

        busy_dly  = dly;
        busy_len  = len;
        start_cnt = 0;
        ENABLE    = 1'b1;
        REQ       = mask;
        REQ_DATA  = data;
        winner    = pickWinner(mask, ptr_model);
        exp_data  = data[8*winner +: 8];
        tmo       = (dly == 0) || (dly + 2 > TMO);

        tick();
        checkOutput("grant_ack", REQ_ACK, 32'(1) << winner);
        checkOutput("grant_tx_start", TX_START, 1);
        checkOutput("grant_id", GRANT_ID, winner);
        checkOutput("grant_tx_data", TX_DATA, exp_data);
        checkOutput("grant_active", ACTIVE, 1);
        ptr_model = (winner + 1) % N_REQ;

        REQ      = (mode == 1) ? N_REQ'($urandom_range(1, (1 << N_REQ) - 1)) : '0;
        REQ_DATA = $urandom;

        hi = 1; tail = 0; errs = 0; acks = 0; unstable = 0; guard = 0; low_seen = 0;
        do begin
            tick();
            guard++;
            if (ERR_TMO === 1'b1) errs++;
            if (REQ_ACK !== '0) acks++;
            if (ACTIVE === 1'b1) begin
                if (TX_DATA !== exp_data) unstable++;
                if (TX_START === 1'b1) begin
                    hi++;
                end else begin
                    tail++;
                    if (!low_seen) begin
                        low_seen = 1;
                        if (mode == 1) REQ = '0;
                        if (mode == 2) begin
                            ENABLE = 1'b0;
                            REQ    = N_REQ'(1);
                        end
                        if (mode == 3) begin
                            RESETN    = 1'b0;
                            TX_BUSY   = 1'b0;
                            busy_rem  = 0;
                            start_cnt = 0;
                            busy_dly  = 0;
                            REQ       = '0;
                            tick();
                            checkOutput("rst_tx_start", TX_START, 0);
                            checkOutput("rst_ack", REQ_ACK, 0);
                            checkOutput("rst_err", ERR_TMO, 0);
                            checkOutput("rst_active", ACTIVE, 0);
                            checkOutput("rst_grant_id", GRANT_ID, 0);
                            checkOutput("rst_tx_data", TX_DATA, 0);
                            RESETN    = 1'b1;
                            ptr_model = 0;
                            return;
                        end
                    end
                end
            end
        end while (ACTIVE === 1'b1 && guard < 400);

        checkOutput("frame_ends_idle", ACTIVE, 0);
        checkOutput("start_len", hi, tmo ? TMO : dly + 2);
        checkOutput("err_pulses", errs, tmo ? 1 : 0);
        checkOutput("extra_acks", acks, 0);
        checkOutput("data_unstable", unstable, 0);
        checkOutput("tail_len", tail, tmo ? GAP : len + GAP);
    endtask

    // Directed scenarios first, then randomized frames.
    initial begin
        int idle_bad;
        int r, dly;

        RESETN   = 1'b0;
        ENABLE   = 1'b0;
        REQ      = '0;
        REQ_DATA = '0;
        TX_BUSY  = 1'b0;
        repeat (3) tick();
        checkOutput("reset_tx_start", TX_START, 0);
        checkOutput("reset_ack", REQ_ACK, 0);
        checkOutput("reset_err", ERR_TMO, 0);
        checkOutput("reset_active", ACTIVE, 0);
        checkOutput("reset_grant_id", GRANT_ID, 0);
        checkOutput("reset_tx_data", TX_DATA, 0);
        RESETN = 1'b1;

        $display("[TB] round-robin with all requests raised");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, $urandom, $urandom_range(1, 6), $urandom_range(3, 8), 0);
        end

        $display("[TB] single requester, byte 0xA5, busy after 3 cycles for 20");
        applyStimulus(4'b0100, {8'h11, 8'hA5, 8'h22, 8'h33}, 3, 20, 0);

        $display("[TB] start timeout then grant from the advanced pointer");
        applyStimulus(4'b0010, $urandom, 0, 5, 0);
        applyStimulus(4'b0110, $urandom, 4, 5, 0);

        $display("[TB] busy arrives on the last timeout cycle");
        applyStimulus(4'b1111, $urandom, TMO - 2, 4, 0);

        $display("[TB] request and data churn after the grant");
        applyStimulus(4'b1001, $urandom, 2, 6, 1);

        $display("[TB] enable dropped during SEND");
        applyStimulus(4'b0100, $urandom, 4, 6, 2);
        idle_bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (REQ_ACK !== '0 || ACTIVE !== 1'b0) idle_bad++;
        end
        checkOutput("gated_no_grant", idle_bad, 0);
        applyStimulus(4'b0001, $urandom, 3, 4, 0);

        $display("[TB] reset during SEND");
        applyStimulus(4'b0100, $urandom, 3, 10, 3);
        applyStimulus(4'b1010, $urandom, 2, 4, 0);

        $display("[TB] randomized frames");
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      dly = 0;
            else if (r == 1) dly = TMO - 2;
            else             dly = $urandom_range(1, 10);
            applyStimulus(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), $urandom, dly,
                          $urandom_range(3, 12), $urandom_range(0, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
